rep_ctrl_wb: RTL and testbench
==============================

REP_CTRL_WB -- requirements
Module: rep_ctrl_wb

Interface
REQ-001 Parameter CNT_W, default 32, count register width; legal values 16 or 32.
REQ-002 Parameter ZF_BIT, default 6, ZF position in current_flags.
REQ-003 Parameter MAX_ITER_W, default 16, width of the iteration statistics counter.
REQ-004 Ports, one per line:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset; asynchronous, active-low.
- WB_V  in  1  WB stage valid.
- WB_FLUSH  in  1  pipeline flush/abort.
- CS_IS_STRING_WB  in  1  uop belongs to a string instruction.
- CS_IS_LAST_UOP_WB  in  1  last uop of one string iteration.
- REP_MODE  in  2  00 none, 01 REP, 10 REPE, 11 REPNE.
- ASIZE16  in  1  16-bit address size; count operates on low 16 bits.
- WB_RESULT_C  in  CNT_W  architectural ECX value at WB.
- current_flags  in  32  post-update flags of the current uop.
- count_out  out  CNT_W  ECX value to write.
- ld_count  out  1  write count_out to ECX this cycle.
- ld_eip  out  1  load EIP this cycle.
- eip_sel  out  1  0 = NEIP (advance), 1 = current EIP (re-execute).
- suppress_wb  out  1  kill memory/GPR writes of this uop.
- rep_active  out  1  state is RUN.
- rep_done  out  1  one-cycle pulse after termination.
- iter_count  out  MAX_ITER_W  iterations completed in the current REP instruction.

Function
REQ-005 A qualifying uop is defined as WB_V=1, WB_FLUSH=0, CS_IS_STRING_WB=1, REP_MODE!=00.
REQ-006 The FSM SHALL have states IDLE and RUN, encoded as a single flop; RUN drives rep_active=1.
REQ-007 Effective count (EC) SHALL be WB_RESULT_C[15:0] when ASIZE16=1, else the full WB_RESULT_C.
REQ-008 IDLE, qualifying uop, EC==0: suppress_wb=1; at the last uop, ld_eip=1 and eip_sel=0; state stays IDLE; rep_done pulses next cycle.
REQ-009 IDLE, qualifying uop, EC!=0: transition to RUN on the next edge; outputs for that uop follow RUN rules (REQ-010..013) in the same cycle.
REQ-010 Non-last uops in IDLE or RUN SHALL drive ld_count=0, ld_eip=0, suppress_wb=0.
REQ-011 At a qualifying last uop: ld_count=1 and count_out=EC-1 within the active width; with ASIZE16=1, count_out[CNT_W-1:16] equals WB_RESULT_C[CNT_W-1:16] unchanged, and the low half wraps modulo 2^16 without borrow into the upper half.
REQ-012 Termination at a last uop is: (EC-1)==0, or REPE and ZF==0, or REPNE and ZF==1; REP ignores ZF.
REQ-013 If terminated: ld_eip=1, eip_sel=0; next state IDLE; rep_done=1 the following cycle; iter_count then holds the final value until the next REP starts. If not terminated: ld_eip=1, eip_sel=1; state stays RUN.
REQ-014 All outputs except rep_done, rep_active and iter_count SHALL be combinational, with zero latency from the WB inputs.
REQ-015 iter_count SHALL clear to 0 on the IDLE->RUN transition, increment at each qualifying last uop, and saturate at all-ones.
REQ-016 WB_FLUSH=1 SHALL force next state IDLE, drive all load outputs to 0, and keep rep_done at 0; flush wins over a simultaneous last uop.
REQ-017 WB_V=0 SHALL hold all state and drive all load outputs to 0.
REQ-018 REP_MODE==00 or CS_IS_STRING_WB=0 SHALL drive all outputs inactive and leave state unchanged; a non-string valid uop in RUN is a protocol error and is ignored.

Reset
REQ-019 CLR=0 SHALL asynchronously force state IDLE, rep_active=0, rep_done=0, iter_count=0.
REQ-020 Reset values of the combinational outputs: ld_count=0, ld_eip=0, eip_sel=0, suppress_wb=0, count_out=0.
REQ-021 Reset asserted mid-RUN SHALL abandon the iteration with no further ld_* activity, regardless of WB inputs.

Verification
REQ-022 REP, ECX=3, single-uop iterations -> ld_count with count_out 2,1,0; eip_sel 1,1,0; rep_done one cycle after the third uop; iter_count=3.
REQ-023 REPNE, ECX=5, ZF=1 on the 2nd iteration -> count_out 4,3; terminates at the 2nd iteration with eip_sel=0; iter_count=2.
REQ-024 REPE, ECX=0 -> suppress_wb=1, ld_count=0, ld_eip=1, eip_sel=0; rep_done pulses; state stays IDLE.
REQ-025 ASIZE16=1, ECX=0xABCD0001, REP -> count_out=0xABCD0000, terminate; with ECX=0x12340000 -> EC=0, skip per REQ-008.
REQ-026 RUN with WB_FLUSH coincident with a last uop -> no ld_count/ld_eip, state IDLE, no rep_done; async CLR low mid-RUN -> rep_active drops immediately.

Source files
------------

// File: rtl/rep_ctrl_wb.sv
// -----------------------------------------------------------------------------
// rep_ctrl_wb
//   Write-back stage controller for x86 REP/REPE/REPNE string instructions.
//   It watches each string uop at WB. At the last uop of every iteration it
//   decrements the count register, then decides one of two actions: re-execute
//   the instruction by reloading the current EIP, or finish by advancing to
//   NEIP. A REP with a zero count is skipped entirely. In that case its writes
//   are suppressed and EIP advances.
//
// Parameters
//   CNT_W       count register width (16 or 32)
//   ZF_BIT      position of ZF inside current_flags
//   MAX_ITER_W  width of the iteration statistics counter
//
// Ports
//   CLK, CLR            clock, asynchronous active-low reset
//   WB_V, WB_FLUSH      WB stage valid and pipeline flush
//   CS_IS_STRING_WB     uop belongs to a string instruction
//   CS_IS_LAST_UOP_WB   last uop of one string iteration
//   REP_MODE            00 none, 01 REP, 10 REPE, 11 REPNE
//   ASIZE16             16-bit address size (count uses the low 16 bits only)
//   WB_RESULT_C         architectural ECX value at WB
//   current_flags       post-update flags of the current uop
//   count_out/ld_count  new ECX value and its write strobe (combinational)
//   ld_eip/eip_sel      EIP load strobe; 0 = advance, 1 = re-execute
//   suppress_wb         kill memory/GPR writes of this uop (zero-count skip)
//   rep_active          a REP instruction is iterating
//   rep_done            one-cycle pulse after a REP instruction terminates
//   iter_count          iterations completed in the current REP instruction
// -----------------------------------------------------------------------------
module rep_ctrl_wb #(
  parameter int CNT_W      = 32,
  parameter int ZF_BIT     = 6,
  parameter int MAX_ITER_W = 16
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  WB_V,
  input  logic                  WB_FLUSH,
  input  logic                  CS_IS_STRING_WB,
  input  logic                  CS_IS_LAST_UOP_WB,
  input  logic [1:0]            REP_MODE,
  input  logic                  ASIZE16,
  input  logic [CNT_W-1:0]      WB_RESULT_C,
  input  logic [31:0]           current_flags,
  output logic [CNT_W-1:0]      count_out,
  output logic                  ld_count,
  output logic                  ld_eip,
  output logic                  eip_sel,
  output logic                  suppress_wb,
  output logic                  rep_active,
  output logic                  rep_done,
  output logic [MAX_ITER_W-1:0] iter_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LOW16_MASK = CNT_W'(32'h0000_FFFF);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t                state_q, state_d;
  logic                  done_d;
  logic [MAX_ITER_W-1:0] iter_q, iter_d;

  logic                  qualifying;
  logic [CNT_W-1:0]      eff_count;
  logic [CNT_W-1:0]      dec_full;
  logic [CNT_W-1:0]      dec_count;
  logic                  ec_is_zero;
  logic                  ec_is_one;
  logic                  zf;
  logic                  terminate;

  // Effective count and its decrement. With a 16-bit address size only the
  // low half counts down. The low half wraps on its own, and the upper half
  // of ECX is passed through untouched, so a borrow never leaks into it.
  always_comb begin
    eff_count  = ASIZE16 ? (WB_RESULT_C & LOW16_MASK) : WB_RESULT_C;
    dec_full   = WB_RESULT_C - CNT_ONE;
    dec_count  = ASIZE16 ? ((WB_RESULT_C & ~LOW16_MASK) | (dec_full & LOW16_MASK))
                         : dec_full;
    ec_is_zero = (eff_count == '0);
    ec_is_one  = (eff_count == CNT_ONE);
    zf         = current_flags[ZF_BIT];
    qualifying = WB_V && !WB_FLUSH && CS_IS_STRING_WB && (REP_MODE != 2'b00);
    terminate  = ec_is_one
               || ((REP_MODE == 2'b10) && !zf)
               || ((REP_MODE == 2'b11) &&  zf);
  end

  // Next-state and output decode. The uop that starts a REP already follows
  // the RUN rules, so a one-iteration REP both starts and finishes in a
  // single cycle. Holding CLR low forces every strobe to zero, which means a
  // reset in the middle of an iteration cannot leak a partial update.
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    done_d      = 1'b0;
    ld_count    = 1'b0;
    ld_eip      = 1'b0;
    eip_sel     = 1'b0;
    suppress_wb = 1'b0;
    count_out   = '0;

    if (WB_FLUSH) begin
      state_d = IDLE;
    end else if (qualifying) begin
      if (state_q == IDLE && ec_is_zero) begin
        suppress_wb = 1'b1;
        if (CS_IS_LAST_UOP_WB) begin
          ld_eip = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        if (state_q == IDLE) begin
          state_d = RUN;
          iter_d  = '0;
        end
        if (CS_IS_LAST_UOP_WB) begin
          ld_count  = 1'b1;
          count_out = dec_count;
          ld_eip    = 1'b1;
          if (state_q == IDLE)
            iter_d = MAX_ITER_W'(1);
          else if (iter_q != '1)
            iter_d = iter_q + MAX_ITER_W'(1);
          if (terminate) begin
            eip_sel = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            eip_sel = 1'b1;
          end
        end
      end
    end

    if (!CLR) begin
      ld_count    = 1'b0;
      ld_eip      = 1'b0;
      eip_sel     = 1'b0;
      suppress_wb = 1'b0;
      count_out   = '0;
    end
  end

  // State register, termination pulse and iteration counter.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= IDLE;
      rep_done <= 1'b0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      rep_done <= done_d;
      iter_q   <= iter_d;
    end
  end

  assign rep_active = (state_q == RUN);
  assign iter_count = iter_q;

endmodule

// File: tb/tb_rep_ctrl_wb.sv
// -----------------------------------------------------------------------------
// tb_rep_ctrl_wb
//   Directed testbench for rep_ctrl_wb with the default parameters
//   (CNT_W=32, ZF_BIT=6, MAX_ITER_W=16). Each scenario task drives uops and
//   compares against hand-computed values. The combinational strobes are
//   checked mid-cycle. The registered outputs are checked 1ns after the edge.
// -----------------------------------------------------------------------------
module tb_rep_ctrl_wb;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        WB_V, WB_FLUSH, CS_IS_STRING_WB, CS_IS_LAST_UOP_WB;
  logic [1:0]  REP_MODE;
  logic        ASIZE16;
  logic [31:0] WB_RESULT_C;
  logic [31:0] current_flags;
  logic [31:0] count_out;
  logic        ld_count, ld_eip, eip_sel, suppress_wb;
  logic        rep_active, rep_done;
  logic [15:0] iter_count;

  int tests_run  = 0;
  int fail_count = 0;

  rep_ctrl_wb dut (
    .CLK               (CLK),
    .CLR               (CLR),
    .WB_V              (WB_V),
    .WB_FLUSH          (WB_FLUSH),
    .CS_IS_STRING_WB   (CS_IS_STRING_WB),
    .CS_IS_LAST_UOP_WB (CS_IS_LAST_UOP_WB),
    .REP_MODE          (REP_MODE),
    .ASIZE16           (ASIZE16),
    .WB_RESULT_C       (WB_RESULT_C),
    .current_flags     (current_flags),
    .count_out         (count_out),
    .ld_count          (ld_count),
    .ld_eip            (ld_eip),
    .eip_sel           (eip_sel),
    .suppress_wb       (suppress_wb),
    .rep_active        (rep_active),
    .rep_done          (rep_done),
    .iter_count        (iter_count)
  );

  always #5 CLK = ~CLK;

  // Drive one WB-stage uop. ZF sits at bit 6; the other flag bits are noise.
  task automatic set_uop(input logic v, input logic fl, input logic str,
                         input logic last, input logic [1:0] mode,
                         input logic a16, input logic [31:0] ecx,
                         input logic zf);
    WB_V              = v;
    WB_FLUSH          = fl;
    CS_IS_STRING_WB   = str;
    CS_IS_LAST_UOP_WB = last;
    REP_MODE          = mode;
    ASIZE16           = a16;
    WB_RESULT_C       = ecx;
    current_flags     = 32'h0000_0883 | ({31'd0, zf} << 6);
  endtask

  task automatic set_idle();
    set_uop(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'd5, 1'b0);
    tick();
    tick();
    tests_run++;
    if ({ld_count, ld_eip, eip_sel, suppress_wb} !== 4'b0000 || count_out !== 32'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_comb strobes=%b count=%h want 0000/0",
               {ld_count, ld_eip, eip_sel, suppress_wb}, count_out);
    end
    tests_run++;
    if ({rep_active, rep_done} !== 2'b00 || iter_count !== 16'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_regs active/done=%b iter=%0d want 00/0",
               {rep_active, rep_done}, iter_count);
    end
    @(negedge CLK);
    set_idle();
    CLR = 1'b1;
  endtask

  // REP, ECX=3, single-uop iterations, with a non-last uop before iteration 2.
  task automatic test_rep_basic();
    logic [31:0] ecx;
    ecx = 32'd3;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        @(negedge CLK);
        set_uop(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, ecx, 1'b0);
        #1;
        tests_run++;
        if ({ld_count, ld_eip, suppress_wb} !== 3'b000) begin
          fail_count++;
          $display("[TB] FAIL rep_nonlast strobes=%b want 000", {ld_count, ld_eip, suppress_wb});
        end
        tick();
      end
      @(negedge CLK);
      set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, ecx, 1'b0);
      #1;
      tests_run++;
      if (count_out !== ecx - 32'd1 || {ld_count, ld_eip, eip_sel, suppress_wb} !== {3'b11, (i != 2), 1'b0}) begin
        fail_count++;
        $display("[TB] FAIL rep_iter%0d count=%h strobes=%b want %h/%b", i, count_out,
                 {ld_count, ld_eip, eip_sel, suppress_wb}, ecx - 32'd1, {3'b11, (i != 2), 1'b0});
      end
      tick();
      tests_run++;
      if (rep_active !== (i != 2) || rep_done !== (i == 2) || iter_count !== 16'(i + 1)) begin
        fail_count++;
        $display("[TB] FAIL rep_state%0d active=%b done=%b iter=%0d want %b/%b/%0d", i,
                 rep_active, rep_done, iter_count, (i != 2), (i == 2), i + 1);
      end
      ecx = ecx - 32'd1;
    end
    @(negedge CLK);
    set_idle();
    tick();
    tests_run++;
    if (rep_done !== 1'b0 || iter_count !== 16'd3) begin
      fail_count++;
      $display("[TB] FAIL rep_hold done=%b iter=%0d want 0/3", rep_done, iter_count);
    end
  endtask

  // REPNE, ECX=5, ZF=1 on the second iteration.
  task automatic test_repne_zf();
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'd5, 1'b0);
    #1;
    tests_run++;
    if (count_out !== 32'd4 || {ld_count, ld_eip, eip_sel} !== 3'b111) begin
      fail_count++;
      $display("[TB] FAIL repne_it1 count=%h strobes=%b want 4/111", count_out, {ld_count, ld_eip, eip_sel});
    end
    tick();
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'd4, 1'b1);
    #1;
    tests_run++;
    if (count_out !== 32'd3 || {ld_count, ld_eip, eip_sel} !== 3'b110) begin
      fail_count++;
      $display("[TB] FAIL repne_it2 count=%h strobes=%b want 3/110", count_out, {ld_count, ld_eip, eip_sel});
    end
    tick();
    tests_run++;
    if (rep_active !== 1'b0 || rep_done !== 1'b1 || iter_count !== 16'd2) begin
      fail_count++;
      $display("[TB] FAIL repne_end active=%b done=%b iter=%0d want 0/1/2", rep_active, rep_done, iter_count);
    end
    @(negedge CLK);
    set_idle();
  endtask

  // REPE with ECX=0: skipped, writes suppressed, EIP advances.
  task automatic test_repe_zero();
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'd0, 1'b1);
    #1;
    tests_run++;
    if ({ld_count, ld_eip, eip_sel, suppress_wb} !== 4'b0101) begin
      fail_count++;
      $display("[TB] FAIL repe_zero strobes=%b want 0101", {ld_count, ld_eip, eip_sel, suppress_wb});
    end
    tick();
    tests_run++;
    if (rep_active !== 1'b0 || rep_done !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL repe_zero_state active=%b done=%b want 0/1", rep_active, rep_done);
    end
    @(negedge CLK);
    set_idle();
  endtask

  // 16-bit address size: only the low half of ECX counts.
  task automatic test_asize16();
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 32'hABCD_0001, 1'b0);
    #1;
    tests_run++;
    if (count_out !== 32'hABCD_0000 || {ld_count, ld_eip, eip_sel, suppress_wb} !== 4'b1100) begin
      fail_count++;
      $display("[TB] FAIL a16_term count=%h strobes=%b want abcd0000/1100", count_out,
               {ld_count, ld_eip, eip_sel, suppress_wb});
    end
    tick();
    tests_run++;
    if (rep_active !== 1'b0 || rep_done !== 1'b1 || iter_count !== 16'd1) begin
      fail_count++;
      $display("[TB] FAIL a16_state active=%b done=%b iter=%0d want 0/1/1", rep_active, rep_done, iter_count);
    end
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 32'h1234_0000, 1'b0);
    #1;
    tests_run++;
    if ({ld_count, ld_eip, eip_sel, suppress_wb} !== 4'b0101) begin
      fail_count++;
      $display("[TB] FAIL a16_skip strobes=%b want 0101", {ld_count, ld_eip, eip_sel, suppress_wb});
    end
    tick();
    tests_run++;
    if (rep_active !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL a16_skip_state active=%b want 0", rep_active);
    end
    @(negedge CLK);
    set_idle();
  endtask

  // Bubbles and non-string uops inside RUN, then a flush on a last uop.
  task automatic test_flush_and_hold();
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'd4, 1'b0);
    tick();
    @(negedge CLK);
    set_uop(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'd3, 1'b0);
    #1;
    tests_run++;
    if ({ld_count, ld_eip, suppress_wb} !== 3'b000) begin
      fail_count++;
      $display("[TB] FAIL bubble strobes=%b want 000", {ld_count, ld_eip, suppress_wb});
    end
    tick();
    tests_run++;
    if (rep_active !== 1'b1 || iter_count !== 16'd1) begin
      fail_count++;
      $display("[TB] FAIL bubble_hold active=%b iter=%0d want 1/1", rep_active, iter_count);
    end
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'd3, 1'b0);
    #1;
    tests_run++;
    if ({ld_count, ld_eip, suppress_wb} !== 3'b000) begin
      fail_count++;
      $display("[TB] FAIL nonstring strobes=%b want 000", {ld_count, ld_eip, suppress_wb});
    end
    tick();
    tests_run++;
    if (rep_active !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL nonstring_hold active=%b want 1", rep_active);
    end
    @(negedge CLK);
    set_uop(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'd1, 1'b0);
    #1;
    tests_run++;
    if ({ld_count, ld_eip, suppress_wb} !== 3'b000) begin
      fail_count++;
      $display("[TB] FAIL flush strobes=%b want 000", {ld_count, ld_eip, suppress_wb});
    end
    tick();
    tests_run++;
    if (rep_active !== 1'b0 || rep_done !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL flush_state active=%b done=%b want 0/0", rep_active, rep_done);
    end
    @(negedge CLK);
    set_idle();
  endtask

  // Asynchronous reset in the middle of RUN while a last uop is presented.
  task automatic test_async_reset();
    @(negedge CLK);
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'd9, 1'b0);
    tick();
    tests_run++;
    if (rep_active !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL arst_pre active=%b want 1", rep_active);
    end
    #2;
    set_uop(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'd8, 1'b0);
    CLR = 1'b0;
    #1;
    tests_run++;
    if (rep_active !== 1'b0 || iter_count !== 16'd0 || {ld_count, ld_eip, eip_sel, suppress_wb} !== 4'b0000) begin
      fail_count++;
      $display("[TB] FAIL arst_mid active=%b iter=%0d strobes=%b want 0/0/0000", rep_active,
               iter_count, {ld_count, ld_eip, eip_sel, suppress_wb});
    end
    @(negedge CLK);
    set_idle();
    CLR = 1'b1;
    tick();
    tests_run++;
    if (rep_active !== 1'b0 || rep_done !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL arst_post active=%b done=%b want 0/0", rep_active, rep_done);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_rep_basic();
    test_repne_zf();
    test_repe_zero();
    test_asize16();
    test_flush_and_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
